// File: rtl/axi4stream_input_buffer_liyongda_if.sv
// ---------------------------------------------------------------------------
// axi4stream_input_buffer_liyongda_if
//
// Purpose : bundles the AXI4-Stream receive side and the assembled-frame
//           valid/ready pair of the input buffer into one interface.
//
// Signals : tdata / tvalid / tlast / tready   - incoming packet stream
//           myBuffer / myBuffer_valid /
//           myBuffer_ready                    - assembled frame to the core
//
// Modports: slave  - the input buffer (stream sink, frame source)
//           master - the environment (stream source, frame sink)
// ---------------------------------------------------------------------------
interface axi4stream_input_buffer_liyongda_if #(
  parameter int PACKET_SIZE   = 8,
  parameter int MYBUFFER_SIZE = 40
);
  logic [PACKET_SIZE-1:0]   tdata;
  logic                     tvalid;
  logic                     tlast;
  logic                     tready;
  logic [MYBUFFER_SIZE-1:0] myBuffer;
  logic                     myBuffer_valid;
  logic                     myBuffer_ready;

  modport slave (
    input  tdata, tvalid, tlast, myBuffer_ready,
    output tready, myBuffer, myBuffer_valid
  );

  modport master (
    output tdata, tvalid, tlast, myBuffer_ready,
    input  tready, myBuffer, myBuffer_valid
  );
endinterface

// File: rtl/axi4stream_input_buffer_liyongda.sv
// ---------------------------------------------------------------------------
// axi4stream_input_buffer_liyongda
//
// Purpose : AXI4-Stream slave that deserializes a packet stream into one wide
//           frame of NROWS x ROW_LENGTH bits. Row 0 sits at the MSB end of
//           myBuffer. Each row takes BPR = ceil(ROW_LENGTH/PACKET_SIZE)
//           beats; the last beat of a row contributes only its low REM bits,
//           which land in the row's lowest bits.
//
// Ports   : aclk             - clock
//           areset           - asynchronous active-low reset
//           bus (slave)      - tdata/tvalid/tlast/tready stream in,
//                              myBuffer/myBuffer_valid/myBuffer_ready out
//           frame_error      - one-cycle pulse on a tlast mismatch
//           probe_state      - FSM state (0 FILL, 1 HOLD)
//           probe_beat_count - beat index within the current frame
//
// Option  : INPUT_BUFFER_DOUBLE_BUF_EN - when defined, a separate output
//           register decouples assembly from delivery so frames can stream
//           back-to-back; when undefined, the assembly register is the output
//           and the stream stalls while a frame is held.
// ---------------------------------------------------------------------------
module axi4stream_input_buffer_liyongda #(
  parameter int PACKET_SIZE   = 8,
  parameter int NROWS         = 2,
  parameter int ROW_LENGTH    = 20,
  parameter int MYBUFFER_SIZE = NROWS * ROW_LENGTH
) (
  input  logic                                  aclk,
  input  logic                                  areset,
  axi4stream_input_buffer_liyongda_if.slave     bus,
  output logic                                  frame_error,
  output logic [1:0]                            probe_state,
  output logic [15:0]                           probe_beat_count
);

  localparam int BPR   = (ROW_LENGTH + PACKET_SIZE - 1) / PACKET_SIZE;
  localparam int REM   = ROW_LENGTH - (BPR - 1) * PACKET_SIZE;
  localparam int COL_W = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int ROW_W = (NROWS > 1) ? $clog2(NROWS) : 1;

  localparam logic [COL_W-1:0]         COL_LAST = COL_W'(BPR - 1);
  localparam logic [ROW_W-1:0]         ROW_LAST = ROW_W'(NROWS - 1);
  localparam logic [MYBUFFER_SIZE-1:0] PKT_MASK = MYBUFFER_SIZE'({PACKET_SIZE{1'b1}});
  localparam logic [MYBUFFER_SIZE-1:0] REM_MASK = MYBUFFER_SIZE'({REM{1'b1}});

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1
  } state_t;

  state_t                   state_r, state_next_s;
  logic [COL_W-1:0]         col_r, col_next_s;
  logic [ROW_W-1:0]         row_r, row_next_s;
  logic [15:0]              beat_cnt_r, beat_cnt_next_s;
  logic                     tready_r;
  logic                     frame_error_r, frame_error_next_s;
  logic [MYBUFFER_SIZE-1:0] asm_r, asm_next_s;
  logic                     out_valid_r, out_valid_next_s;
`ifdef INPUT_BUFFER_DOUBLE_BUF_EN
  logic [MYBUFFER_SIZE-1:0] out_r, out_next_s;
`endif

  logic xfer_s;
  logic last_beat_s;
  logic early_last_s;
  logic release_s;

  // Writes one beat into its slot of the frame. Masks are shifted rather
  // than part-selected so the row/column arithmetic stays in plain integers.
  function automatic logic [MYBUFFER_SIZE-1:0] place_beat(
    input logic [MYBUFFER_SIZE-1:0] frame,
    input logic [PACKET_SIZE-1:0]   data,
    input int                       row,
    input int                       col
  );
    logic [MYBUFFER_SIZE-1:0] wide_data;
    int                       shift;
    wide_data = MYBUFFER_SIZE'(data);
    if (col < BPR - 1) begin
      shift      = MYBUFFER_SIZE - row * ROW_LENGTH - (col + 1) * PACKET_SIZE;
      place_beat = (frame & ~(PKT_MASK << shift)) | (wide_data << shift);
    end else begin
      // Final beat of a row: only the low REM bits of tdata are kept.
      shift      = MYBUFFER_SIZE - (row + 1) * ROW_LENGTH;
      place_beat = (frame & ~(REM_MASK << shift)) | ((wide_data & REM_MASK) << shift);
    end
  endfunction

  // Handshake and frame-position decodes.
  always_comb begin
    xfer_s       = bus.tvalid & tready_r;
    last_beat_s  = (col_r == COL_LAST) && (row_r == ROW_LAST);
    early_last_s = xfer_s & bus.tlast & ~last_beat_s;
    release_s    = out_valid_r & bus.myBuffer_ready;
  end

  // Next-state, counter and buffer update logic.
  always_comb begin
    state_next_s       = state_r;
    col_next_s         = col_r;
    row_next_s         = row_r;
    beat_cnt_next_s    = beat_cnt_r;
    asm_next_s         = asm_r;
    frame_error_next_s = 1'b0;
    // A consumed frame clears valid unless a new frame is loaded below.
    out_valid_next_s   = out_valid_r & ~release_s;
`ifdef INPUT_BUFFER_DOUBLE_BUF_EN
    out_next_s         = out_r;
`endif
    case (state_r)
      ST_FILL: begin
        if (xfer_s) begin
          if (early_last_s) begin
            // Premature tlast: drop the partial frame and restart at beat 0.
            col_next_s         = '0;
            row_next_s         = '0;
            beat_cnt_next_s    = 16'd0;
            frame_error_next_s = 1'b1;
          end else begin
            asm_next_s = place_beat(asm_r, bus.tdata, int'(row_r), int'(col_r));
            if (last_beat_s) begin
              col_next_s         = '0;
              row_next_s         = '0;
              beat_cnt_next_s    = 16'd0;
              // Frame is still delivered when tlast is missing, but flagged.
              frame_error_next_s = ~bus.tlast;
`ifdef INPUT_BUFFER_DOUBLE_BUF_EN
              if (!out_valid_r || release_s) begin
                out_next_s       = asm_next_s;
                out_valid_next_s = 1'b1;
              end else begin
                // Output still occupied: park the frame and stall the stream.
                state_next_s     = ST_HOLD;
              end
`else
              state_next_s     = ST_HOLD;
              out_valid_next_s = 1'b1;
`endif
            end else begin
              beat_cnt_next_s = beat_cnt_r + 16'd1;
              if (col_r == COL_LAST) begin
                col_next_s = '0;
                row_next_s = row_r + ROW_W'(1);
              end else begin
                col_next_s = col_r + COL_W'(1);
              end
            end
          end
        end else begin
          state_next_s = ST_FILL;
        end
      end
      ST_HOLD: begin
        if (release_s) begin
          state_next_s = ST_FILL;
`ifdef INPUT_BUFFER_DOUBLE_BUF_EN
          out_next_s       = asm_r;
          out_valid_next_s = 1'b1;
`endif
        end else begin
          state_next_s = ST_HOLD;
        end
      end
      default: begin
        state_next_s = ST_FILL;
      end
    endcase
  end

  // State, counters, frame storage and registered outputs.
  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      state_r       <= ST_FILL;
      col_r         <= '0;
      row_r         <= '0;
      beat_cnt_r    <= 16'd0;
      tready_r      <= 1'b0;
      frame_error_r <= 1'b0;
      asm_r         <= '0;
      out_valid_r   <= 1'b0;
`ifdef INPUT_BUFFER_DOUBLE_BUF_EN
      out_r         <= '0;
`endif
    end else begin
      state_r       <= state_next_s;
      col_r         <= col_next_s;
      row_r         <= row_next_s;
      beat_cnt_r    <= beat_cnt_next_s;
      // Ready tracks the state being entered so it drops on the completing edge.
      tready_r      <= (state_next_s == ST_FILL);
      frame_error_r <= frame_error_next_s;
      asm_r         <= asm_next_s;
      out_valid_r   <= out_valid_next_s;
`ifdef INPUT_BUFFER_DOUBLE_BUF_EN
      out_r         <= out_next_s;
`endif
    end
  end

  assign bus.tready         = tready_r;
  assign bus.myBuffer_valid = out_valid_r;
`ifdef INPUT_BUFFER_DOUBLE_BUF_EN
  assign bus.myBuffer       = out_r;
`else
  assign bus.myBuffer       = asm_r;
`endif
  assign frame_error        = frame_error_r;
  assign probe_state        = state_r;
  assign probe_beat_count   = beat_cnt_r;

endmodule

// File: tb/tb_axi4stream_input_buffer_liyongda.sv
// ---------------------------------------------------------------------------
// tb_axi4stream_input_buffer_liyongda
//
// Drives directed and random packet streams into the input buffer and checks
// delivered frames against a row-concatenation model of the frame layout.
// ---------------------------------------------------------------------------
module tb_axi4stream_input_buffer_liyongda;

  localparam int PS    = 8;
  localparam int NR    = 2;
  localparam int RL    = 20;
  localparam int MB    = NR * RL;
  localparam int BPR   = (RL + PS - 1) / PS;
  localparam int REM   = RL - (BPR - 1) * PS;
  localparam int TOTAL = NR * BPR;
`ifdef INPUT_BUFFER_DOUBLE_BUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        frame_error;
  logic [1:0]  probe_state;
  logic [15:0] probe_beat_count;

  int vectors     = 0;
  int miscompares = 0;
  int fe_seen     = 0;
  int exp_fe      = 0;
  bit cons_ready  = 1'b1;
  bit rand_ready  = 1'b0;
  longint hs_t    = 0;
  longint start_t = 0;
  longint t0      = 0;

  logic [MB-1:0] exp_q [$];
  logic [7:0]    mb [TOTAL];
  logic [7:0]    fixed_b [TOTAL];

  axi4stream_input_buffer_liyongda_if #(.PACKET_SIZE(PS), .MYBUFFER_SIZE(MB)) bus ();

  axi4stream_input_buffer_liyongda #(
    .PACKET_SIZE(PS), .NROWS(NR), .ROW_LENGTH(RL)
  ) dut (
    .aclk             (aclk),
    .areset           (areset),
    .bus              (bus),
    .frame_error      (frame_error),
    .probe_state      (probe_state),
    .probe_beat_count (probe_beat_count)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame = rows concatenated MSB-first; row = beats concatenated, last beat trimmed to REM bits.
  function automatic logic [MB-1:0] model_frame();
    logic [MB-1:0] fr;
    logic [RL-1:0] row;
    fr = '0;
    for (int r = 0; r < NR; r++) begin
      row = '0;
      for (int c = 0; c < BPR; c++) begin
        if (c < BPR - 1) row = (row << PS) | RL'(mb[r*BPR+c]);
        else             row = (row << REM) | RL'(mb[r*BPR+c] & 8'((1 << REM) - 1));
      end
      fr = (fr << RL) | MB'(row);
    end
    return fr;
  endfunction

  task automatic send_beat(input logic [7:0] d, input logic l);
    int guard;
    guard = 0;
    @(negedge aclk);
    bus.tvalid = 1'b1;
    bus.tdata  = d;
    bus.tlast  = l;
    while (bus.tready !== 1'b1 && guard < 200) begin
      @(negedge aclk);
      guard++;
    end
    if (guard >= 200) chk("tready_timeout", 64'd0, 64'd1);
    @(posedge aclk);
    hs_t = $time;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge aclk);
      bus.tvalid = 1'b0;
      bus.tlast  = 1'b0;
    end
  endtask

  task automatic send_frame(input int gap_max, input bit omit_last, input int early_at,
                            input bit use_fixed, input bit probe_chk);
    logic [7:0] d;
    for (int k = 0; k < TOTAL; k++) begin
      d = use_fixed ? fixed_b[k] : 8'($urandom);
      mb[k] = d;
      send_beat(d, (k == TOTAL - 1) ? ~omit_last : (k == early_at));
      if (k == 0) start_t = hs_t;
      if (k == TOTAL - 1) begin
        exp_q.push_back(model_frame());
        if (omit_last) exp_fe++;
      end
      if (k == early_at) begin
        exp_fe++;
        break;
      end
      if (probe_chk) begin
        #1;
        chk("probe_after_hs", probe_beat_count, 64'((k + 1) % TOTAL));
        idle(1);
        @(posedge aclk);
        #1;
        chk("probe_idle", probe_beat_count, 64'((k + 1) % TOTAL));
      end else if (gap_max > 0 && k < TOTAL - 1) begin
        idle($urandom_range(0, gap_max));
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge aclk);
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Consumer side: drives myBuffer_ready and scoreboards every presented frame.
  initial begin
    forever begin
      @(negedge aclk);
      bus.myBuffer_ready = rand_ready ? ($urandom_range(0, 3) != 0) : cons_ready;
      if (areset === 1'b1) begin
        if (frame_error === 1'b1) fe_seen++;
        if (bus.myBuffer_valid === 1'b1) begin
          if (exp_q.size() == 0) chk("unexpected_frame", 64'd1, 64'd0);
          else begin
            chk("frame", 64'(bus.myBuffer), 64'(exp_q[0]));
            if (bus.myBuffer_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    bus.tvalid = 1'b0;
    bus.tdata  = 8'h00;
    bus.tlast  = 1'b0;
    areset     = 1'b0;
    fixed_b    = '{8'hA5, 8'h3C, 8'hF7, 8'h12, 8'h34, 8'hE9};

    // Reset state
    repeat (3) @(negedge aclk);
    chk("rst_tready", bus.tready, 64'd0);
    chk("rst_valid", bus.myBuffer_valid, 64'd0);
    chk("rst_buffer", 64'(bus.myBuffer), 64'd0);
    chk("rst_frame_error", frame_error, 64'd0);
    chk("rst_state", probe_state, 64'd0);
    chk("rst_count", probe_beat_count, 64'd0);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    chk("tready_rise", bus.tready, 64'd1);

    // Directed frame with 1-cycle valid latency
    for (int k = 0; k < TOTAL; k++) begin
      mb[k] = fixed_b[k];
      send_beat(fixed_b[k], k == TOTAL - 1);
      if (k == TOTAL - 2) begin
        #1;
        chk("valid_before_last", bus.myBuffer_valid, 64'd0);
      end
    end
    exp_q.push_back(model_frame());
    #1;
    chk("valid_after_last", bus.myBuffer_valid, 64'd1);
    chk("directed_frame", 64'(bus.myBuffer), 64'h00_A53C7_12349);
    chk("directed_no_error", frame_error, 64'd0);
    chk("state_after_last", probe_state, DBUF ? 64'd0 : 64'd1);
    idle(2);

    // Same frame with tvalid toggling, probe counter tracked per handshake
    send_frame(0, 1'b0, -1, 1'b1, 1'b1);
    idle(2);
    wait_drain();

    // Early tlast discards, then a good frame
    send_frame(0, 1'b0, 2, 1'b0, 1'b0);
    idle(3);
    chk("fe_after_early", 64'(fe_seen), 64'(exp_fe));
    chk("no_frame_after_early", 64'(exp_q.size()), 64'd0);
    send_frame(1, 1'b0, -1, 1'b0, 1'b0);
    idle(1);
    wait_drain();

    // Consumer stalls for 10 cycles
    @(posedge aclk);
    #1;
    cons_ready = 1'b0;
    send_frame(0, 1'b0, -1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      bus.tvalid = 1'b0;
      bus.tlast  = 1'b0;
      chk("hold_tready", bus.tready, DBUF ? 64'd1 : 64'd0);
      chk("hold_valid", bus.myBuffer_valid, 64'd1);
    end
    @(posedge aclk);
    #1;
    cons_ready = 1'b1;
    @(posedge aclk);
    #1;
    chk("tready_after_release", bus.tready, 64'd1);
    chk("valid_after_release", bus.myBuffer_valid, 64'd0);

    // Reset in the middle of a frame
    for (int k = 0; k < 4; k++) send_beat(8'($urandom), 1'b0);
    @(negedge aclk);
    bus.tvalid = 1'b0;
    areset     = 1'b0;
    @(negedge aclk);
    chk("midrst_valid", bus.myBuffer_valid, 64'd0);
    chk("midrst_buffer", 64'(bus.myBuffer), 64'd0);
    chk("midrst_count", probe_beat_count, 64'd0);
    chk("midrst_tready", bus.tready, 64'd0);
    areset = 1'b1;
    @(posedge aclk);
    #1;
    send_frame(0, 1'b0, -1, 1'b0, 1'b0);
    idle(1);
    wait_drain();

    // Back-to-back frames with a ready consumer
    idle(2);
    send_frame(0, 1'b0, -1, 1'b0, 1'b0);
    t0 = start_t;
    send_frame(0, 1'b0, -1, 1'b0, 1'b0);
    chk("b2b_cycles", 64'((hs_t - t0) / 10 + 1), DBUF ? 64'd12 : 64'd13);
    idle(2);
    wait_drain();

    // Random frames, gaps, tlast faults and consumer backpressure
    rand_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      send_frame(2, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, TOTAL - 2)) : -1,
                 1'b0, 1'b0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rand_ready = 1'b0;
    idle(3);
    wait_drain();
    chk("fe_total", 64'(fe_seen), 64'(exp_fe));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
